// File: rtl/fir_out_decimator.sv
// fir_out_decimator: integrate-and-dump decimator (ratio 2^LOG2_DECIM) behind the FIR filters.
// It scales by 2^-(LOG2_DECIM+OUT_SHIFT), saturates to OUT_W bits and buffers results in a 2-entry FIFO.
// Latency: a dump sample is captured at edge t, dump_v is high after t+1, and y_out/out_valid are valid after t+2.
// Backpressure: out_valid/out_ready. When a result arrives at a full FIFO with no pop, it is dropped and ovf is set (sticky).
// Ports: clk, rst (async active-low), in_valid/y_in (signed samples), phase_clr (frame restart),
//        out_valid/out_ready/y_out (FIFO head, 0 when empty), ovf (sticky drop flag).
// Build option: define FIR_DEC_ROUND_EN to round half toward +inf. Otherwise results truncate toward -inf.
module fir_out_decimator #(
  parameter int IN_W       = 18,
  parameter int OUT_W      = 8,
  parameter int LOG2_DECIM = 2,
  parameter int OUT_SHIFT  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  y_in,
  input  logic                    phase_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y_out,
  output logic                    ovf
);

  localparam int ACC_W = IN_W + LOG2_DECIM;
  localparam int SW    = ACC_W + 1;          // one spare bit so the rounding add cannot wrap
  localparam int S     = LOG2_DECIM + OUT_SHIFT;
  localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;
  localparam logic signed [SW-1:0]  SAT_MAX  = SW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0]  SAT_MIN  = ~SAT_MAX;
`ifdef FIR_DEC_ROUND_EN
  localparam logic [SW-1:0] RND = {{(SW-1){1'b0}}, 1'b1} << (S - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  // Input capture stage: isolates the FIR output timing from the accumulator adder.
  logic                   in_vld_q, clr_q;
  logic [IN_W-1:0]        in_dat_q;

  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [LOG2_DECIM-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]       dump_q, dump_d;
  logic                   dump_v_q, dump_v_d;

  logic [ACC_W-1:0]       samp_ext, acc_sum;

  always_comb begin
    samp_ext = {{LOG2_DECIM{in_dat_q[IN_W-1]}}, in_dat_q};
    acc_sum  = acc_q + samp_ext;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dump_d   = dump_q;
    dump_v_d = 1'b0;
    if (clr_q) begin
      // A restart that carries a sample makes that sample index 0 of the new frame.
      if (in_vld_q) begin
        acc_d = samp_ext;
        cnt_d = LOG2_DECIM'(1);
      end else begin
        acc_d = '0;
        cnt_d = '0;
      end
    end else if (in_vld_q) begin
      if (cnt_q == CNT_LAST) begin
        dump_d   = acc_sum;
        dump_v_d = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + LOG2_DECIM'(1);
      end
    end
  end

  // Scale, round and saturate the dumped sum.
  logic [SW-1:0]          sum_r;
  logic signed [SW-1:0]   shr;
  logic signed [OUT_W-1:0] sat_val;

  always_comb begin
    sum_r = {dump_q[ACC_W-1], dump_q} + RND;
    shr   = $signed(sum_r) >>> S;
    if (shr > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
    else if (shr < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
    else                    sat_val = shr[OUT_W-1:0];
  end

  // Two-entry FIFO.
  logic [OUT_W-1:0] mem_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       fcnt_q;
  logic             ovf_q;
  logic             pop, push_ok, full;

  assign full      = (fcnt_q == 2'd2);
  assign out_valid = (fcnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  // Space frees up in the same cycle as a pop, so a full FIFO still accepts the result.
  assign push_ok   = dump_v_q & (~full | pop);
  assign y_out     = out_valid ? $signed(mem_q[rd_q]) : '0;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_vld_q <= 1'b0;
      clr_q    <= 1'b0;
      in_dat_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dump_q   <= '0;
      dump_v_q <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      fcnt_q   <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      in_vld_q <= in_valid;
      clr_q    <= phase_clr;
      in_dat_q <= y_in;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dump_q   <= dump_d;
      dump_v_q <= dump_v_d;
      if (push_ok) begin
        mem_q[wr_q] <= sat_val;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      if (dump_v_q && full && !pop) ovf_q <= 1'b1;
      if (push_ok && !pop)      fcnt_q <= fcnt_q + 2'd1;
      else if (!push_ok && pop) fcnt_q <= fcnt_q - 2'd1;
    end
  end

endmodule

// File: tb/tb_fir_out_decimator.sv
module tb_fir_out_decimator;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [17:0] y_in;
  logic              phase_clr;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] y_out;
  logic              ovf;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef FIR_DEC_ROUND_EN
  localparam int EXP_2047 = 2;
`else
  localparam int EXP_2047 = 1;
`endif

  always #5 clk = ~clk;

  fir_out_decimator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .y_in      (y_in),
    .phase_clr (phase_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_out     (y_out),
    .ovf       (ovf)
  );

  // One sample cycle. It returns 1ns after the edge that captured the sample.
  task automatic drive(input logic signed [17:0] d, input logic clr);
    in_valid  = 1'b1;
    y_in      = d;
    phase_clr = clr;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    phase_clr = 1'b0;
    y_in      = '0;
  endtask

  task automatic frame(input logic signed [17:0] d);
    for (int i = 0; i < 4; i++) drive(d, 1'b0);
  endtask

  // Observe the output for a bounded number of cycles, counting the cycles where the head is valid.
  task automatic collect(input int cycles, output int n, output logic signed [7:0] first);
    n = 0;
    first = '0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (n == 0) first = y_out;
        n++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; y_in = '0; phase_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vec_cnt++; if (y_out !== 8'sd0) begin err_cnt++; $display("FAIL reset_y_out got %0d want 0", y_out); end
    vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf got %b want 0", ovf); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency;
    out_ready = 1'b1;
    frame(18'sd1024);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL lat_t0 out_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL lat_t1 out_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL lat_t2 out_valid got %b want 1", out_valid); end
    vec_cnt++; if (y_out !== 8'sd1) begin err_cnt++; $display("FAIL lat_t2 y_out got %0d want 1", y_out); end
    @(posedge clk); #1;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL lat_t3 out_valid got %b want 0", out_valid); end
    vec_cnt++; if (y_out !== 8'sd0) begin err_cnt++; $display("FAIL lat_t3 y_out got %0d want 0", y_out); end
  endtask

  task automatic test_round;
    int n; logic signed [7:0] v; logic signed [7:0] exp;
    exp = 8'(EXP_2047);
    frame(18'sd2047);
    collect(6, n, v);
    vec_cnt++; if (n !== 1) begin err_cnt++; $display("FAIL round_count got %0d want 1", n); end
    vec_cnt++; if (v !== exp) begin err_cnt++; $display("FAIL round_value got %0d want %0d", v, exp); end
  endtask

  task automatic test_saturation;
    int n; logic signed [7:0] v; logic signed [7:0] exp;
    frame(18'sd131071);
    collect(6, n, v);
    exp = 8'sd127;
    vec_cnt++; if (n !== 1 || v !== exp) begin err_cnt++; $display("FAIL sat_pos got %0d (n=%0d) want %0d", v, n, exp); end
    frame(-18'sd131072);
    collect(6, n, v);
    exp = -8'sd128;
    vec_cnt++; if (n !== 1 || v !== exp) begin err_cnt++; $display("FAIL sat_neg got %0d (n=%0d) want %0d", v, n, exp); end
  endtask

  task automatic test_overflow;
    int pops;
    out_ready = 1'b0;
    frame(18'sd4096);
    frame(18'sd4096);
    vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL ovf_early got %b want 0", ovf); end
    frame(18'sd4096);
    repeat (4) @(posedge clk); #1;
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL ovf_held_valid got %b want 1", out_valid); end
    vec_cnt++; if (y_out !== 8'sd4) begin err_cnt++; $display("FAIL ovf_head got %0d want 4", y_out); end
    vec_cnt++; if (ovf !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag got %b want 1", ovf); end
    out_ready = 1'b1;
    pops = 0;
    repeat (5) begin
      if (out_valid) begin
        pops++;
        vec_cnt++; if (y_out !== 8'sd4) begin err_cnt++; $display("FAIL ovf_pop_value got %0d want 4", y_out); end
      end
      @(posedge clk); #1;
    end
    vec_cnt++; if (pops !== 2) begin err_cnt++; $display("FAIL ovf_pop_count got %0d want 2", pops); end
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL ovf_drained got %b want 0", out_valid); end
    vec_cnt++; if (ovf !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    rst = 1'b0; #1;
    vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL ovf_reset_clear got %b want 0", ovf); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_pop;
    out_ready = 1'b0;
    frame(18'sd4096);
    frame(18'sd8192);
    frame(18'sd12288);
    // The third result is pushed on the second edge after its last sample; pop on that same edge.
    @(posedge clk); #1;
    vec_cnt++; if (out_valid !== 1'b1 || y_out !== 8'sd4) begin err_cnt++; $display("FAIL fp_head0 got %0d (v=%b) want 4", y_out, out_valid); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vec_cnt++; if (ovf !== 1'b0) begin err_cnt++; $display("FAIL fp_ovf got %b want 0", ovf); end
    vec_cnt++; if (out_valid !== 1'b1 || y_out !== 8'sd8) begin err_cnt++; $display("FAIL fp_head1 got %0d (v=%b) want 8", y_out, out_valid); end
    @(posedge clk); #1;
    vec_cnt++; if (y_out !== 8'sd8) begin err_cnt++; $display("FAIL fp_hold got %0d want 8", y_out); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vec_cnt++; if (out_valid !== 1'b1 || y_out !== 8'sd12) begin err_cnt++; $display("FAIL fp_head2 got %0d (v=%b) want 12", y_out, out_valid); end
    @(posedge clk); #1;
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL fp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_phase_clr;
    int n; logic signed [7:0] v;
    out_ready = 1'b1;
    drive(18'sd1024, 1'b0);
    drive(18'sd1024, 1'b0);
    drive(18'sd1024, 1'b1);
    drive(18'sd1024, 1'b0);
    drive(18'sd1024, 1'b0);
    drive(18'sd1024, 1'b0);
    collect(8, n, v);
    vec_cnt++; if (n !== 1) begin err_cnt++; $display("FAIL pclr_count got %0d want 1", n); end
    vec_cnt++; if (v !== 8'sd1) begin err_cnt++; $display("FAIL pclr_value got %0d want 1", v); end
    // The restarted frame must have ended exactly on a boundary.
    frame(18'sd2048);
    collect(6, n, v);
    vec_cnt++; if (n !== 1 || v !== 8'sd2) begin err_cnt++; $display("FAIL pclr_next_frame got %0d (n=%0d) want 2", v, n); end
  endtask

  task automatic test_reset_mid;
    int n; logic signed [7:0] v;
    out_ready = 1'b1;
    drive(18'sd16384, 1'b0);
    drive(18'sd16384, 1'b0);
    rst = 1'b0; #1;
    vec_cnt++; if (out_valid !== 1'b0 || y_out !== 8'sd0) begin err_cnt++; $display("FAIL rmid_during got %0d (v=%b) want 0", y_out, out_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    collect(6, n, v);
    vec_cnt++; if (n !== 0) begin err_cnt++; $display("FAIL rmid_no_output got %0d want 0", n); end
    // Samples with idle gaps: the accumulator holds between them.
    for (int i = 0; i < 4; i++) begin
      drive(18'sd1024, 1'b0);
      @(posedge clk); #1;
    end
    collect(6, n, v);
    vec_cnt++; if (n !== 1 || v !== 8'sd1) begin err_cnt++; $display("FAIL rmid_after got %0d (n=%0d) want 1", v, n); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_round;
    test_saturation;
    test_overflow;
    test_full_pop;
    test_phase_clr;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
